// File: rtl/ni_inject_arbiter_if.sv
// ni_inject_arbiter_if: requester-side and FIFO-write-side signals of the NI inject arbiter.
interface ni_inject_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 32,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic [DSIZE-1:0]      wdata;
    logic                  winc;
    logic                  wfull;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic [15:0]           pkt_count;
    modport slave (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, wdata, winc, grant_id, busy, pkt_count
    );
    modport master (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, wdata, winc, grant_id, busy, pkt_count
    );
endinterface

// File: rtl/ni_inject_arbiter.sv
// ni_inject_arbiter: round-robin, packet-locked sharing of the NI async FIFO write port
// between NREQ requesters, entirely in the write-clock domain.
module ni_inject_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 32,
    parameter int IDW   = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    ni_inject_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]      pkt_count_q, pkt_count_d;
    logic [IDW-1:0]   pick, g_next;
    logic [DSIZE-1:0] sel_data;
    logic             sel_valid, sel_last, lock, xfer;
    int               idx;
    // Scan offsets high to low so the requester nearest rr_ptr is the one left in pick.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_valid[idx[IDW-1:0]]) pick = idx[IDW-1:0];
        end
    end
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                sel_data  = bus.req_data[i*DSIZE +: DSIZE];
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
            end
        end
    end
    assign g_next = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign lock   = state_q == LOCK;
    assign xfer   = lock && sel_valid && !bus.wfull;
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_count_d = pkt_count_q;
        if (!lock && |bus.req_valid) begin
            state_d    = LOCK;
            grant_id_d = pick;
        end
        if (xfer && sel_last) begin
            state_d     = IDLE;
            rr_ptr_d    = g_next;
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            bus.req_ready[i] = lock && !bus.wfull && grant_id_q == IDW'(i);
    end
    assign bus.wdata     = lock ? sel_data : '0;
    assign bus.winc      = xfer;
    assign bus.busy      = lock;
    assign bus.grant_id  = grant_id_q;
    assign bus.pkt_count = pkt_count_q;
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            pkt_count_q <= pkt_count_d;
        end
    end
endmodule
